// File: rtl/piece_move_controller.sv
// Active-piece movement sequencer: latches move requests, offers candidates
// to the collision checker, and commits, discards or locks the piece.
module piece_move_controller #(
  parameter int X_W     = 4,
  parameter int Y_W     = 5,
  parameter int NUM_ROT = 4,
  parameter int SPAWN_X = 4,
  parameter int SPAWN_Y = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mv_left,
  input  logic           mv_right,
  input  logic           mv_rot,
  input  logic           mv_down,
  output logic           chk_req,
  output logic [X_W-1:0] chk_x,
  output logic [Y_W-1:0] chk_y,
  output logic [2:0]     chk_rot,
  input  logic           chk_done,
  input  logic           chk_hit,
  output logic [X_W-1:0] piece_x,
  output logic [Y_W-1:0] piece_y,
  output logic [2:0]     piece_rot,
  output logic           lock_pulse,
  output logic           busy,
  output logic           game_over
);

  typedef enum logic [2:0] {
    IDLE, CHECK, LOCK, SPAWN, OVER
  } state_t;

  localparam logic [X_W-1:0] SX   = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0] SY   = Y_W'(SPAWN_Y);
  localparam logic [2:0]     RMAX = 3'(NUM_ROT - 1);

  // request bit order: [3] rot, [2] left, [1] right, [0] down
  state_t         state, state_n;
  logic [3:0]     pend, pend_n, req, eff, clr, taken;
  logic [X_W-1:0] cx, cx_n;
  logic [Y_W-1:0] cy, cy_n;
  logic [2:0]     cr, cr_n;
  logic           dn, dn_n;
  logic           commit;

  always_comb begin
    req     = {mv_rot, mv_left, mv_right, mv_down};
    eff     = pend | req;
    state_n = state;
    clr     = '0;
    taken   = '0;
    cx_n    = cx;
    cy_n    = cy;
    cr_n    = cr;
    dn_n    = dn;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        cx_n = piece_x;
        cy_n = piece_y;
        cr_n = piece_rot;
        dn_n = 1'b0;
        if (eff[3]) begin
          clr[3]  = 1'b1;
          cr_n    = (piece_rot == RMAX) ? 3'd0 : piece_rot + 3'd1;
          state_n = CHECK;
        end else if (eff[2]) begin
          clr[2] = 1'b1;
          if (piece_x != '0) begin
            cx_n    = piece_x - X_W'(1);
            state_n = CHECK;
          end
        end else if (eff[1]) begin
          clr[1]  = 1'b1;
          cx_n    = piece_x + X_W'(1);
          state_n = CHECK;
        end else if (eff[0]) begin
          clr[0]  = 1'b1;
          cy_n    = piece_y + Y_W'(1);
          dn_n    = 1'b1;
          state_n = CHECK;
        end
        // a fresh pulse is consumed by its own launch; an old one re-arms
        taken = clr & ~pend;
      end
      CHECK: begin
        if (chk_done) begin
          commit  = !chk_hit;
          state_n = (chk_hit && dn) ? LOCK : IDLE;
        end
      end
      LOCK: begin
        clr[0]  = 1'b1;
        cx_n    = SX;
        cy_n    = SY;
        cr_n    = 3'd0;
        state_n = SPAWN;
      end
      SPAWN: begin
        if (chk_done) begin
          commit  = !chk_hit;
          state_n = chk_hit ? OVER : IDLE;
        end
      end
      OVER: state_n = OVER;
      default: state_n = IDLE;
    endcase
    pend_n = (state == OVER) ? 4'd0 : ((pend & ~clr) | (req & ~taken));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      cx        <= SX;
      cy        <= SY;
      cr        <= 3'd0;
      dn        <= 1'b0;
      piece_x   <= SX;
      piece_y   <= SY;
      piece_rot <= 3'd0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      cx    <= cx_n;
      cy    <= cy_n;
      cr    <= cr_n;
      dn    <= dn_n;
      if (commit) begin
        piece_x   <= cx;
        piece_y   <= cy;
        piece_rot <= cr;
      end
    end
  end

  assign chk_req    = (state == CHECK) || (state == SPAWN);
  assign chk_x      = cx;
  assign chk_y      = cy;
  assign chk_rot    = cr;
  assign lock_pulse = (state == LOCK);
  assign busy       = (state != IDLE);
  assign game_over  = (state == OVER);

endmodule
